// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-side constants and the IF/ID register type
package cpu_pkg;

  localparam int          PC_W_DEFAULT = 9;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  // pc is kept at full width so the type does not depend on PC_W; users slice it.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory port and IF/ID outputs of the fetch stage
interface if_stage_if #(
  parameter int PC_W = cpu_pkg::PC_W_DEFAULT
);

  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            if_id_valid;
  logic [PC_W-1:0] if_id_pc;
  logic [31:0]     if_id_instr;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    output if_id_valid,
    output if_id_pc,
    output if_id_instr
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    input  if_id_valid,
    input  if_id_pc,
    input  if_id_instr
  );

endinterface

// File: rtl/if_stage_fetch_skid_buf.sv
// rtl/if_stage_fetch_skid_buf.sv - one-entry buffer holding the read that returns during a stall
module fetch_skid_buf
  import cpu_pkg::if_id_t;
#(
  parameter int PC_W = cpu_pkg::PC_W_DEFAULT
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic            fetch_vld,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic [31:0]     rdata,
  output if_id_t          entry
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      entry.valid <= 1'b0;
    end else if (stall) begin
      // Only the first stall cycle sees real read data; later cycles must not overwrite it.
      if (fetch_vld && !entry.valid) begin
        entry.valid <= 1'b1;
        entry.pc    <= 32'(fetch_pc);
        entry.instr <= rdata;
      end
    end else begin
      entry.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: owns the PC, drives imem, produces IF/ID
// Optional IF_STAGE_PERF_CNT_EN adds saturating flush/stall cycle counters.
module if_stage
  import cpu_pkg::if_id_t;
#(
  parameter int              PC_W      = cpu_pkg::PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(cpu_pkg::RESET_PC),
  parameter logic [31:0]     NOP_INSTR = cpu_pkg::NOP_INSTR
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        pc_sel,
  input  logic [31:0] branch_target,
  if_stage_if.master  bus
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fetch_pc_q;
  logic            fetch_vld_q;
  if_id_t          if_id_q;
  if_id_t          skid;
  logic [PC_W-1:0] target_pc;
  logic            unused_bits;

  assign target_pc   = {branch_target[PC_W-1:2], 2'b00};
  assign unused_bits = ^{branch_target[31:PC_W], branch_target[1:0], if_id_q.pc[31:PC_W]};

  assign bus.imem_en     = !reset && (!stall || pc_sel);
  assign bus.imem_addr   = pc_q;
  assign bus.if_id_valid = if_id_q.valid;
  assign bus.if_id_pc    = if_id_q.pc[PC_W-1:0];
  assign bus.if_id_instr = if_id_q.instr;

  fetch_skid_buf #(
    .PC_W (PC_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (pc_sel),
    .stall     (stall),
    .fetch_vld (fetch_vld_q),
    .fetch_pc  (fetch_pc_q),
    .rdata     (bus.imem_rdata),
    .entry     (skid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      fetch_pc_q  <= '0;
      fetch_vld_q <= 1'b0;
      if_id_q     <= '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR};
    end else if (pc_sel) begin
      // The wrong-path read issued this cycle is dropped by clearing fetch_vld_q.
      pc_q          <= target_pc;
      fetch_vld_q   <= 1'b0;
      if_id_q.valid <= 1'b0;
      if_id_q.instr <= NOP_INSTR;
    end else if (!stall) begin
      pc_q          <= pc_q + PC_W'(4);
      fetch_pc_q    <= pc_q;
      fetch_vld_q   <= 1'b1;
      if_id_q.valid <= fetch_vld_q;
      if_id_q.pc    <= skid.valid ? skid.pc : 32'(fetch_pc_q);
      if (!fetch_vld_q)
        if_id_q.instr <= NOP_INSTR;
      else
        if_id_q.instr <= skid.valid ? skid.instr : bus.imem_rdata;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pc_sel && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (stall && !pc_sel && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector bench for if_stage
module tb_if_stage;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [8:0]  DEAD_ADDR = 9'h124;

  typedef struct {
    logic        r;
    logic        s;
    logic        p;
    logic [31:0] t;
    logic        en;
    logic [8:0]  addr;
    logic        v;
    logic [8:0]  pc;
    logic [31:0] instr;
    logic        chk_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pc_sel;
  logic [31:0] branch_target;
  logic [31:0] garbage = 32'h0;
  logic        cur_en;
  logic [8:0]  cur_addr;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[$];

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_stage_if #(.PC_W(9)) bus ();

  if_stage #(.PC_W(9)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .bus           (bus)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return (a == DEAD_ADDR) ? 32'hDEAD_BEEF : (32'h1000_0000 | {23'd0, a});
  endfunction

  // Synchronous-read memory; disabled cycles return changing garbage.
  always @(posedge clk) begin
    garbage <= garbage + 32'h0001_0001;
    bus.imem_rdata <= bus.imem_en ? mem_word(bus.imem_addr) : (32'hBAD0_0000 ^ garbage);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic p, input logic [31:0] t);
    @(negedge clk);
    reset = r; stall = s; pc_sel = p; branch_target = t;
    #1;
    cur_en   = bus.imem_en;
    cur_addr = bus.imem_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string name, input logic v, input logic [8:0] pc, input logic [31:0] ins);
    chk({name, " valid"}, {31'd0, bus.if_id_valid}, {31'd0, v});
    chk({name, " pc"}, {23'd0, bus.if_id_pc}, {23'd0, pc});
    chk({name, " instr"}, bus.if_id_instr, ins);
  endtask

  function automatic vec_t mk(logic r, logic s, logic p, logic [31:0] t, logic en, logic [8:0] a,
                              logic v, logic [8:0] pc, logic [31:0] ins, logic cp);
    vec_t x;
    x.r = r; x.s = s; x.p = p; x.t = t; x.en = en; x.addr = a;
    x.v = v; x.pc = pc; x.instr = ins; x.chk_pc = cp;
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall = 1'b0; pc_sel = 1'b0; branch_target = 32'h0;
    @(posedge clk);
    #1;

    //                r  s  p  target         en addr    v  pc      instr                cp
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 9'h000, 0, 9'h000, NOP,                 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h000, 0, 9'h000, NOP,                 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h004, 1, 9'h000, mem_word(9'h000),    1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h008, 1, 9'h004, mem_word(9'h004),    1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h00C, 1, 9'h008, mem_word(9'h008),    1));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_0123, 1, 9'h010, 0, 9'h000, NOP,                 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h120, 0, 9'h000, NOP,                 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h124, 1, 9'h120, mem_word(9'h120),    1));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 9'h128, 1, 9'h120, mem_word(9'h120),    1));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 9'h128, 1, 9'h120, mem_word(9'h120),    1));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 9'h128, 1, 9'h120, mem_word(9'h120),    1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h128, 1, 9'h124, 32'hDEAD_BEEF,       1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h12C, 1, 9'h128, mem_word(9'h128),    1));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 9'h130, 1, 9'h128, mem_word(9'h128),    1));
    vecs.push_back(mk(0, 1, 1, 32'h0000_0040, 1, 9'h130, 0, 9'h000, NOP,                 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h040, 0, 9'h000, NOP,                 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h044, 1, 9'h040, mem_word(9'h040),    1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h048, 1, 9'h044, mem_word(9'h044),    1));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 9'h04C, 0, 9'h000, NOP,                 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 9'h000, 0, 9'h000, NOP,                 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h000, 0, 9'h000, NOP,                 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h004, 1, 9'h000, mem_word(9'h000),    1));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 9'h008, 1, 9'h004, mem_word(9'h004),    1));

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].t);
      chk($sformatf("vec%0d imem_en", i), {31'd0, cur_en}, {31'd0, vecs[i].en});
      chk($sformatf("vec%0d imem_addr", i), {23'd0, cur_addr}, {23'd0, vecs[i].addr});
      chk($sformatf("vec%0d valid", i), {31'd0, bus.if_id_valid}, {31'd0, vecs[i].v});
      if (vecs[i].chk_pc)
        chk($sformatf("vec%0d pc", i), {23'd0, bus.if_id_pc}, {23'd0, vecs[i].pc});
      chk($sformatf("vec%0d instr", i), bus.if_id_instr, vecs[i].instr);
    end

    // Wrap-around from 0x1FC to 0x000 with no gap.
    cyc(0, 0, 1, 32'h0000_01FC);
    cyc(0, 0, 0, 32'h0);
    chk("wrap addr0", {23'd0, cur_addr}, 32'h1FC);
    chk("wrap bubble", {31'd0, bus.if_id_valid}, 32'd0);
    cyc(0, 0, 0, 32'h0);
    chk("wrap addr1", {23'd0, cur_addr}, 32'h000);
    chk_ifid("wrap first", 1'b1, 9'h1FC, mem_word(9'h1FC));
    cyc(0, 0, 0, 32'h0);
    chk_ifid("wrap second", 1'b1, 9'h000, mem_word(9'h000));

    // Reset while the skid holds an entry; the entry must never surface.
    cyc(0, 1, 0, 32'h0);
    chk_ifid("pre-reset hold", 1'b1, 9'h000, mem_word(9'h000));
    cyc(1, 1, 0, 32'h0);
    chk("midstall reset imem_en", {31'd0, cur_en}, 32'd0);
    chk_ifid("midstall reset", 1'b0, 9'h000, NOP);
    cyc(0, 0, 0, 32'h0);
    chk("post-reset bubble", {31'd0, bus.if_id_valid}, 32'd0);
    cyc(0, 0, 0, 32'h0);
    chk_ifid("post-reset first", 1'b1, 9'h000, mem_word(9'h000));
    cyc(0, 0, 0, 32'h0);
    chk_ifid("post-reset second", 1'b1, 9'h004, mem_word(9'h004));

`ifdef IF_STAGE_PERF_CNT_EN
    cyc(1, 0, 0, 32'h0);
    chk("perf flush reset", perf_flush_cnt, 32'd0);
    chk("perf stall reset", perf_stall_cnt, 32'd0);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 1, 32'h0000_0080);
    cyc(0, 0, 0, 32'h0);
    chk("perf stall count", perf_stall_cnt, 32'd3);
    chk("perf flush count", perf_flush_cnt, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
